fwd_bypass_unit: RTL

Parametrised operand-forwarding unit for the pipelined datapath. It replaces the fixed 3-input forwarding mux with a registered history of in-flight producers (MEM, WB, and deeper stages). It selects each EX-stage operand from the youngest matching producer, and raises a load-use stall when that producer's data is not yet available. It sits between the ID/EX register outputs and the ALU operand inputs.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_match.sv | 50 +++++
 rtl/fwd_bypass_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding unit.
// fwd_entry_t is the default-width producer record; the top re-declares it at its own widths.
package fwd_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_REG_BITS = 5;
    localparam int REG_ZERO     = 0;

    typedef struct packed {
        logic                    valid;
        logic [DEF_REG_BITS-1:0] rd;
        logic [DEF_WIDTH-1:0]    data;
        logic                    ready;
    } fwd_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority matcher: picks the youngest valid producer of src.
// A not-ready youngest match stalls rather than falling back to an older copy.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  REG_BITS = 5,
    parameter int  DEPTH    = 2,
    parameter type entry_t  = fwd_entry_t
) (
    input  entry_t                         entries [DEPTH],
    input  logic [REG_BITS-1:0]            src,
    input  logic [WIDTH-1:0]               rf,
    output logic [sel_width(DEPTH)-1:0]    sel,
    output logic [WIDTH-1:0]               data,
    output logic                           stall
);

    localparam int SEL_W = sel_width(DEPTH);

    logic [DEPTH-1:0] hit_s;

    // Per-entry match; register zero never matches
    always_comb begin
        hit_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            hit_s[k] = entries[k].valid && (entries[k].rd == src) &&
                       (src != REG_BITS'(REG_ZERO));
        end
    end

    // Walk oldest to youngest so the lowest matching index is the last writer
    always_comb begin
        sel   = {SEL_W{1'b0}};
        data  = rf;
        stall = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_s[k]) begin
                sel   = entries[k].ready ? SEL_W'(k + 1) : {SEL_W{1'b0}};
                data  = entries[k].ready ? entries[k].data : rf;
                stall = ~entries[k].ready;
            end else begin
                sel   = sel;
                data  = data;
                stall = stall;
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: shift register of in-flight producers with load fill,
// two priority matchers (A/B) and a saturating stall-cycle counter.
module fwd_bypass_unit
    import fwd_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pipe_en,
    input  logic                         flush,
    input  logic                         prod_valid,
    input  logic [REG_BITS-1:0]          prod_rd,
    input  logic [WIDTH-1:0]             prod_data,
    input  logic                         prod_is_load,
    input  logic                         ld_fill_valid,
    input  logic [WIDTH-1:0]             ld_fill_data,
    input  logic [REG_BITS-1:0]          src_a,
    input  logic [REG_BITS-1:0]          src_b,
    input  logic [WIDTH-1:0]             rf_a,
    input  logic [WIDTH-1:0]             rf_b,
    output logic [WIDTH-1:0]             op_a,
    output logic [WIDTH-1:0]             op_b,
    output logic [sel_width(DEPTH)-1:0]  sel_a,
    output logic [sel_width(DEPTH)-1:0]  sel_b,
    output logic                         stall,
    output logic [CNT_BITS-1:0]          stall_cnt
);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic [WIDTH-1:0]    data;
        logic                ready;
    } entry_t;

    entry_t              entries_q [DEPTH];
    entry_t              entries_d [DEPTH];
    entry_t              filled_s;
    logic                fill_s;
    logic                stall_a_s;
    logic                stall_b_s;
    logic [CNT_BITS-1:0] stall_cnt_q;
    logic [CNT_BITS-1:0] stall_cnt_d;

    // Entry 0 with any pending load fill applied; feeds both hold and shift paths
    always_comb begin
        fill_s   = ld_fill_valid && entries_q[0].valid && !entries_q[0].ready;
        filled_s = entries_q[0];
        if (fill_s) begin
            filled_s.data  = ld_fill_data;
            filled_s.ready = 1'b1;
        end else begin
            filled_s = entries_q[0];
        end
    end

    // Next-state of the producer history
    always_comb begin
        entries_d = entries_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_d[k] = '{valid: 1'b0, rd: {REG_BITS{1'b0}},
                                 data: {WIDTH{1'b0}}, ready: 1'b0};
            end
        end else if (pipe_en) begin
            entries_d[0] = '{valid: prod_valid, rd: prod_rd,
                             data: prod_data, ready: ~prod_is_load};
            for (int k = 1; k < DEPTH; k++) begin
                entries_d[k] = (k == 1) ? filled_s : entries_q[k-1];
            end
        end else begin
            entries_d[0] = filled_s;
        end
    end

    // Saturating stall counter
    always_comb begin
        if (stall && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= '{valid: 1'b0, rd: {REG_BITS{1'b0}},
                                  data: {WIDTH{1'b0}}, ready: 1'b0};
            end
            stall_cnt_q <= {CNT_BITS{1'b0}};
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_match #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .entry_t(entry_t)
    ) u_match_a (
        .entries(entries_q), .src(src_a), .rf(rf_a),
        .sel(sel_a), .data(op_a), .stall(stall_a_s)
    );

    fwd_match #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .entry_t(entry_t)
    ) u_match_b (
        .entries(entries_q), .src(src_b), .rf(rf_b),
        .sel(sel_b), .data(op_b), .stall(stall_b_s)
    );

    assign stall     = stall_a_s | stall_b_s;
    assign stall_cnt = stall_cnt_q;

endmodule
